// File: rtl/lfsr_sync_checker_if.sv
// Serial bit stream into the LFSR sync checker and its lock/error/digit status back out.
interface lfsr_sync_checker_if;
  logic       in_valid;
  logic       in_bit;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [3:0] digit;

  modport master (
    output in_valid, in_bit,
    input  locked, err_pulse, err_count, digit
  );

  modport slave (
    input  in_valid, in_bit,
    output locked, err_pulse, err_count, digit
  );
endinterface

// File: rtl/lfsr_sync_checker.sv
// Self-synchronizing checker for the 5-bit game LFSR (feedback h[4]^h[3]).
// Refills history, proves LOCK_N clean predictions, then tracks windowed mismatches.
module lfsr_sync_checker #(
  parameter int LOCK_N     = 8,
  parameter int WINDOW     = 16,
  parameter int UNLOCK_ERR = 3
) (
  input logic clk,
  input logic reset,
  lfsr_sync_checker_if.slave bus
);

  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_N);
  localparam logic [7:0] WIN_TARGET  = 8'(WINDOW);
  localparam logic [7:0] ERR_TARGET  = 8'(UNLOCK_ERR);

  state_t     state;
  logic [4:0] h;
  logic [2:0] fill_cnt;
  logic [3:0] match_cnt;
  logic [7:0] win_cnt;
  logic [7:0] win_err;
  logic [7:0] err_count;
  logic       err_pulse;
  logic       pred;
  logic       miss;

  // Prediction always uses the pre-shift history; the received bit is what gets shifted in.
  assign pred = h[4] ^ h[3];
  assign miss = bus.in_bit != pred;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      h         <= 5'd0;
      fill_cnt  <= 3'd0;
      match_cnt <= 4'd0;
      win_cnt   <= 8'd0;
      win_err   <= 8'd0;
      err_count <= 8'd0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bus.in_valid) begin
        h <= {h[3:0], bus.in_bit};
        unique case (state)
          FILL: begin
            fill_cnt <= fill_cnt + 3'd1;
            if (fill_cnt == 3'd4) begin
              state     <= VERIFY;
              match_cnt <= 4'd0;
            end
          end
          VERIFY: begin
            // An all-zero history predicts zero forever, so it never earns credit.
            if (!miss && h != 5'd0) begin
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt == LOCK_TARGET - 4'd1) begin
                state   <= LOCKED;
                win_cnt <= 8'd0;
                win_err <= 8'd0;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (miss) begin
              err_pulse <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            // The closing bit's mismatch belongs to the old window, so unlock wins over rollover.
            if (miss && win_err == ERR_TARGET - 8'd1) begin
              state    <= FILL;
              fill_cnt <= 3'd0;
            end else if (win_cnt == WIN_TARGET - 8'd1) begin
              win_cnt <= 8'd0;
              win_err <= 8'd0;
            end else begin
              win_cnt <= win_cnt + 8'd1;
              win_err <= win_err + 8'(miss);
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;
  assign bus.digit     = (state == LOCKED) ? 4'(h % 5'd10) : 4'd0;

endmodule
